fmv_ddr_arbiter: RTL and testbench

- Device-side responder for the FMV worker DDR port.
- Accepts read and write requests from `NUM_PORTS` macroblock workers, each acting as host, and grants one at a time with round-robin fairness.
- Forwards the granted request to the single shared DDR port. Read beats go back to the owning worker.
- Sits between the per-worker DDR ports and the top-level DDR channel at base 0x30000000; addresses pass through unchanged.

---
 rtl/fmv_ddr_pkg.sv | 23 ++
 rtl/fmv_ddr_arbiter_if.sv | 44 ++++
 rtl/fmv_ddr_arbiter_rr_pick.sv | 27 ++
 rtl/fmv_ddr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fmv_ddr_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmv_ddr_pkg.sv
// Shared widths, constants and state type for the FMV worker DDR arbiter.
package fmv_ddr_pkg;

    localparam int DDR_ADDR_W  = 29;
    localparam int DDR_DATA_W  = 64;
    localparam int DDR_BURST_W = 8;

    // Top nibble of the DDR channel window (0x30000000) seen by the workers.
    localparam logic [3:0] DDR_CORE_BASE = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        RDATA,
        HOLD
    } ddr_arb_state_e;

    // Index of the final beat of a read burst; a zero count behaves as one beat.
    function automatic logic [DDR_BURST_W-1:0] last_beat_idx(input logic [DDR_BURST_W-1:0] burstcnt);
        return (burstcnt == '0) ? '0 : burstcnt - 1'b1;
    endfunction

endpackage

// File: rtl/fmv_ddr_arbiter_if.sv
// Bundle of the per-worker DDR ports and the shared downstream DDR port.
// The arbiter uses the slave view; workers plus the DDR channel use master.
interface fmv_ddr_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    import fmv_ddr_pkg::*;

    logic [NUM_PORTS-1:0]                     w_acquire;
    logic [NUM_PORTS-1:0]                     w_read;
    logic [NUM_PORTS-1:0]                     w_write;
    logic [NUM_PORTS-1:0][DDR_ADDR_W-1:0]     w_addr;
    logic [NUM_PORTS-1:0][DDR_BURST_W-1:0]    w_burstcnt;
    logic [NUM_PORTS-1:0][DDR_DATA_W-1:0]     w_wdata;
    logic [NUM_PORTS-1:0][DDR_DATA_W/8-1:0]   w_byteenable;
    logic [NUM_PORTS-1:0]                     w_busy;
    logic [DDR_DATA_W-1:0]                    w_rdata;
    logic [NUM_PORTS-1:0]                     w_rdata_ready;

    logic                                     ddr_acquire;
    logic                                     ddr_read;
    logic                                     ddr_write;
    logic [DDR_ADDR_W-1:0]                    ddr_addr;
    logic [DDR_BURST_W-1:0]                   ddr_burstcnt;
    logic [DDR_DATA_W-1:0]                    ddr_wdata;
    logic [DDR_DATA_W/8-1:0]                  ddr_byteenable;
    logic                                     ddr_busy;
    logic [DDR_DATA_W-1:0]                    ddr_rdata;
    logic                                     ddr_rdata_ready;

    modport slave (
        input  w_acquire, w_read, w_write, w_addr, w_burstcnt, w_wdata, w_byteenable,
        output w_busy, w_rdata, w_rdata_ready,
        output ddr_acquire, ddr_read, ddr_write, ddr_addr, ddr_burstcnt, ddr_wdata, ddr_byteenable,
        input  ddr_busy, ddr_rdata, ddr_rdata_ready
    );

    modport master (
        output w_acquire, w_read, w_write, w_addr, w_burstcnt, w_wdata, w_byteenable,
        input  w_busy, w_rdata, w_rdata_ready,
        input  ddr_acquire, ddr_read, ddr_write, ddr_addr, ddr_burstcnt, ddr_wdata, ddr_byteenable,
        output ddr_busy, ddr_rdata, ddr_rdata_ready
    );

endinterface

// File: rtl/fmv_ddr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last' in cyclic order.
module ddr_rr_pick #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [$clog2(NUM_PORTS)-1:0] last,
    output logic                         valid,
    output logic [$clog2(NUM_PORTS)-1:0] pick
);

    int idx;

    // Scan from the farthest offset back to the nearest so the closest requester wins.
    always_comb begin
        valid = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int off = NUM_PORTS; off >= 1; off--) begin
            idx = (int'(last) + off) % NUM_PORTS;
            if (req[idx]) begin
                valid = 1'b1;
                pick  = idx[$clog2(NUM_PORTS)-1:0];
            end
        end
    end

endmodule

// File: rtl/fmv_ddr_arbiter.sv
// Lets NUM_PORTS macroblock workers share the single DDR channel port.
// One worker owns the channel from grant until it drops acquire; read beats
// are routed straight back to the owner, addresses pass through unchanged.
module fmv_ddr_arbiter
    import fmv_ddr_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic             clk_mpeg,
    input  logic             reset_dsp_enabled_clk_mpeg,
    fmv_ddr_arbiter_if.slave ddr_if
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    ddr_arb_state_e           state, state_d;
    logic [IDX_W-1:0]         owner, owner_d;
    logic [IDX_W-1:0]         last_owner, last_owner_d;
    logic [DDR_BURST_W-1:0]   beat_cnt, beat_cnt_d;
    logic                     acq_q, acq_d;
    logic                     rd_q, rd_d;
    logic                     wr_q, wr_d;
    logic [DDR_ADDR_W-1:0]    addr_q, addr_d;
    logic [DDR_BURST_W-1:0]   burst_q, burst_d;
    logic [DDR_DATA_W-1:0]    wdata_q, wdata_d;
    logic [DDR_DATA_W/8-1:0]  be_q, be_d;

    logic [NUM_PORTS-1:0]     req;
    logic                     pick_valid;
    logic [IDX_W-1:0]         pick;
    logic                     load;
    logic [IDX_W-1:0]         src;

    assign req = ddr_if.w_acquire & (ddr_if.w_read | ddr_if.w_write);

    ddr_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req   (req),
        .last  (last_owner),
        .valid (pick_valid),
        .pick  (pick)
    );

    // Register the arbitration state and the latched downstream command.
    always_ff @(posedge clk_mpeg) begin
        if (reset_dsp_enabled_clk_mpeg) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_PORTS - 1);
            beat_cnt   <= '0;
            acq_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            burst_q    <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_owner <= last_owner_d;
            beat_cnt   <= beat_cnt_d;
            acq_q      <= acq_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
        end
    end

    // Next state: grant in IDLE, forward until accepted, count read beats, then
    // either release the lock or take the owner's follow-up command in HOLD.
    always_comb begin
        state_d      = state;
        owner_d      = owner;
        last_owner_d = last_owner;
        beat_cnt_d   = beat_cnt;
        acq_d        = acq_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        burst_d      = burst_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        load         = 1'b0;
        src          = owner;

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    load         = 1'b1;
                    src          = pick;
                    owner_d      = pick;
                    last_owner_d = pick;
                    acq_d        = 1'b1;
                    state_d      = FWD;
                end
            end
            FWD: begin
                if (!ddr_if.ddr_busy) begin
                    rd_d       = 1'b0;
                    wr_d       = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = rd_q ? RDATA : HOLD;
                end
            end
            RDATA: begin
                if (ddr_if.ddr_rdata_ready) begin
                    beat_cnt_d = beat_cnt + 1'b1;
                    if (beat_cnt == last_beat_idx(burst_q)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!ddr_if.w_acquire[owner]) begin
                    acq_d   = 1'b0;
                    state_d = IDLE;
                end else if (req[owner]) begin
                    load    = 1'b1;
                    state_d = FWD;
                end
            end
            default: state_d = IDLE;
        endcase

        // A read takes precedence if a worker raises both strobes at once.
        if (load) begin
            rd_d    = ddr_if.w_read[src];
            wr_d    = ddr_if.w_write[src] & ~ddr_if.w_read[src];
            addr_d  = ddr_if.w_addr[src];
            burst_d = ddr_if.w_burstcnt[src];
            wdata_d = ddr_if.w_wdata[src];
            be_d    = ddr_if.w_byteenable[src];
        end
    end

    // Worker-facing handshake: only the owner in FWD sees the downstream busy,
    // and read beat strobes reach the owner only while a burst is in flight.
    always_comb begin
        ddr_if.w_busy        = '1;
        ddr_if.w_rdata_ready = '0;
        if (state == FWD) begin
            ddr_if.w_busy[owner] = ddr_if.ddr_busy;
        end
        if (state == RDATA) begin
            ddr_if.w_rdata_ready[owner] = ddr_if.ddr_rdata_ready;
        end
    end

    assign ddr_if.w_rdata        = ddr_if.ddr_rdata;
    assign ddr_if.ddr_acquire    = acq_q;
    assign ddr_if.ddr_read       = rd_q;
    assign ddr_if.ddr_write      = wr_q;
    assign ddr_if.ddr_addr       = addr_q;
    assign ddr_if.ddr_burstcnt   = burst_q;
    assign ddr_if.ddr_wdata      = wdata_q;
    assign ddr_if.ddr_byteenable = be_q;

    // Multi-beat writes are not carried through the channel; flag them in simulation.
    ddr_write_single_beat: assert property (
        @(posedge clk_mpeg) disable iff (reset_dsp_enabled_clk_mpeg)
        wr_q |-> (burst_q == 8'd1)
    );

endmodule

// File: tb/tb_fmv_ddr_arbiter.sv
// Self-checking bench for fmv_ddr_arbiter with four worker ports.
module tb_fmv_ddr_arbiter;

    logic clk_mpeg;
    logic reset_dsp_enabled_clk_mpeg;

    fmv_ddr_arbiter_if #(.NUM_PORTS(4)) bus ();

    fmv_ddr_arbiter #(
        .NUM_PORTS (4)
    ) dut (
        .clk_mpeg                   (clk_mpeg),
        .reset_dsp_enabled_clk_mpeg (reset_dsp_enabled_clk_mpeg),
        .ddr_if                     (bus)
    );

    int checks;
    int errors;

    // Reference model: outstanding requesters and the most recent grant.
    bit   [3:0]  pend;
    int          model_last;
    logic [28:0] e_addr  [4];
    logic [7:0]  e_burst [4];
    logic [63:0] e_wdata [4];
    logic [7:0]  e_be    [4];
    bit          e_wr    [4];

    initial clk_mpeg = 1'b0;
    always #5 clk_mpeg = ~clk_mpeg;

    // Hard stop if the run wanders off.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(negedge clk_mpeg);
    endtask

    // Round-robin rule: the first pending port after the last grant, cyclically.
    function automatic int model_pick(input bit [3:0] pending, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (pending[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [28:0] rand_addr(input int p);
        logic [31:0] r;
        r = $urandom;
        return {r[26:0], 2'(p)};
    endfunction

    task automatic clear_inputs();
        bus.w_acquire       = '0;
        bus.w_read          = '0;
        bus.w_write         = '0;
        bus.w_addr          = '0;
        bus.w_burstcnt      = '0;
        bus.w_wdata         = '0;
        bus.w_byteenable    = '0;
        bus.ddr_busy        = 1'b0;
        bus.ddr_rdata       = '0;
        bus.ddr_rdata_ready = 1'b0;
    endtask

    task automatic set_request(input int p, input bit wr, input logic [28:0] addr,
                               input logic [7:0] burst, input logic [63:0] wdata, input logic [7:0] be);
        e_addr[p]  = addr;
        e_wr[p]    = wr;
        e_burst[p] = burst;
        e_wdata[p] = wdata;
        e_be[p]    = be;
        bus.w_acquire[p]    = 1'b1;
        bus.w_read[p]       = !wr;
        bus.w_write[p]      = wr;
        bus.w_addr[p]       = addr;
        bus.w_burstcnt[p]   = burst;
        bus.w_wdata[p]      = wdata;
        bus.w_byteenable[p] = be;
    endtask

    // Act as the DDR channel and the owning worker for one transaction of port p.
    task automatic serve_txn(input int p, input bit rel, input int busy_n, input int gap_max,
                             input logic [63:0] data0);
        int           waited;
        int           beats;
        int           gap;
        logic [3:0]   own;
        logic [111:0] exp_cmd;
        logic [111:0] act_cmd;
        logic [63:0]  d;
        own    = 4'b0001 << p;
        waited = 0;
        do begin
            cyc();
            #1;
            waited++;
        end while (!(bus.ddr_read | bus.ddr_write) && waited < 40);
        checks++;
        if (waited != 1) begin
            errors++;
            $display("[TB] FAIL grant_latency port %0d: got %0d cycles, expected 1", p, waited);
        end
        if (!(bus.ddr_read | bus.ddr_write)) return;

        exp_cmd = {1'b1, !e_wr[p], e_wr[p], e_addr[p], e_burst[p], e_wdata[p], e_be[p]};
        act_cmd = {bus.ddr_acquire, bus.ddr_read, bus.ddr_write, bus.ddr_addr,
                   bus.ddr_burstcnt, bus.ddr_wdata, bus.ddr_byteenable};
        checks++;
        if (act_cmd !== exp_cmd) begin
            errors++;
            $display("[TB] FAIL cmd_fields port %0d: got %h, expected %h", p, act_cmd, exp_cmd);
        end

        for (int i = 0; i < busy_n; i++) begin
            bus.ddr_busy = 1'b1;
            #1;
            checks++;
            if (bus.w_busy !== 4'hF) begin
                errors++;
                $display("[TB] FAIL stalled_busy port %0d: got %b, expected 1111", p, bus.w_busy);
            end
            cyc();
        end
        bus.ddr_busy = 1'b0;
        #1;
        checks++;
        if (bus.w_busy !== ~own) begin
            errors++;
            $display("[TB] FAIL accept_busy port %0d: got %b, expected %b", p, bus.w_busy, ~own);
        end
        cyc();
        bus.w_read[p]  = 1'b0;
        bus.w_write[p] = 1'b0;
        #1;
        checks++;
        if ({bus.ddr_read, bus.ddr_write} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL cmd_cleared port %0d: got %b, expected 00", p, {bus.ddr_read, bus.ddr_write});
        end

        if (!e_wr[p]) begin
            beats = (e_burst[p] == 8'd0) ? 1 : int'(e_burst[p]);
            for (int b = 0; b < beats; b++) begin
                gap = $urandom_range(0, gap_max);
                for (int g = 0; g < gap; g++) begin
                    bus.ddr_rdata_ready = 1'b0;
                    #1;
                    checks++;
                    if (bus.w_rdata_ready !== 4'h0) begin
                        errors++;
                        $display("[TB] FAIL gap_ready port %0d: got %b, expected 0000", p, bus.w_rdata_ready);
                    end
                    cyc();
                end
                d = (data0 != 64'h0) ? data0 + 64'(b) : {$urandom, $urandom};
                bus.ddr_rdata       = d;
                bus.ddr_rdata_ready = 1'b1;
                #1;
                checks++;
                if (bus.w_rdata_ready !== own || bus.w_rdata !== d) begin
                    errors++;
                    $display("[TB] FAIL beat port %0d #%0d: got ready %b data %h, expected ready %b data %h",
                             p, b, bus.w_rdata_ready, bus.w_rdata, own, d);
                end
                cyc();
            end
        end

        // Lock still held; a stray beat strobe here must not reach anyone.
        bus.ddr_rdata_ready = 1'b1;
        #1;
        checks++;
        if ({bus.ddr_acquire, bus.w_busy, bus.w_rdata_ready} !== {1'b1, 4'hF, 4'h0}) begin
            errors++;
            $display("[TB] FAIL hold_outputs port %0d: got %b, expected 1_1111_0000", p,
                     {bus.ddr_acquire, bus.w_busy, bus.w_rdata_ready});
        end
        if (rel) begin
            bus.w_acquire[p] = 1'b0;
            cyc();
            bus.ddr_rdata_ready = 1'b0;
            #1;
            checks++;
            if ({bus.ddr_acquire, bus.w_busy, bus.w_rdata_ready} !== {1'b0, 4'hF, 4'h0}) begin
                errors++;
                $display("[TB] FAIL release_idle port %0d: got %b, expected 0_1111_0000", p,
                         {bus.ddr_acquire, bus.w_busy, bus.w_rdata_ready});
            end
        end else begin
            bus.ddr_rdata_ready = 1'b0;
        end
    endtask

    // Serve every outstanding request in the order the round-robin rule dictates.
    task automatic drain(input int busy_max, input int gap_max);
        int p;
        while (pend != 4'h0) begin
            p = model_pick(pend, model_last);
            serve_txn(p, 1'b1, $urandom_range(0, busy_max), gap_max, 64'h0);
            pend[p]    = 1'b0;
            model_last = p;
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        clear_inputs();
        reset_dsp_enabled_clk_mpeg = 1'b1;
        cyc();
        cyc();
        reset_dsp_enabled_clk_mpeg = 1'b0;
        #1;
        checks++;
        if ({bus.ddr_acquire, bus.ddr_read, bus.ddr_write, bus.ddr_addr, bus.ddr_burstcnt,
             bus.ddr_wdata, bus.ddr_byteenable} !== 112'h0) begin
            errors++;
            $display("[TB] FAIL reset_cmd: got %h, expected 0", {bus.ddr_acquire, bus.ddr_read,
                     bus.ddr_write, bus.ddr_addr, bus.ddr_burstcnt, bus.ddr_wdata, bus.ddr_byteenable});
        end
        checks++;
        if ({bus.w_busy, bus.w_rdata_ready} !== 8'hF0) begin
            errors++;
            $display("[TB] FAIL reset_worker: got %b, expected 1111_0000", {bus.w_busy, bus.w_rdata_ready});
        end
        pend       = 4'h0;
        model_last = 3;
    endtask

    task automatic test_round_robin();
        $display("[TB] test_round_robin");
        for (int p = 0; p < 4; p++) set_request(p, 1'b0, rand_addr(p), 8'd1, 64'h0, 8'hFF);
        pend = 4'hF;
        drain(1, 0);
        set_request(2, 1'b0, rand_addr(2), 8'd1, 64'h0, 8'hFF);
        set_request(3, 1'b0, rand_addr(3), 8'd1, 64'h0, 8'hFF);
        pend = 4'b1100;
        serve_txn(model_pick(pend, model_last), 1'b1, 0, 0, 64'h0);
        pend[2]    = 1'b0;
        model_last = 2;
        set_request(2, 1'b0, rand_addr(2), 8'd1, 64'h0, 8'hFF);
        set_request(0, 1'b0, rand_addr(0), 8'd1, 64'h0, 8'hFF);
        pend = pend | 4'b0101;
        drain(0, 1);
    endtask

    task automatic test_single_read();
        $display("[TB] test_single_read");
        set_request(0, 1'b0, 29'h3000010, 8'd3, 64'h0, 8'hFF);
        serve_txn(0, 1'b1, 2, 0, 64'hA);
        model_last = 0;
    endtask

    task automatic test_write();
        $display("[TB] test_write");
        set_request(1, 1'b1, rand_addr(1), 8'd1, 64'h11223344_00000000, 8'hF0);
        pend = 4'b0010;
        drain(0, 0);
    endtask

    task automatic test_hold_lock();
        $display("[TB] test_hold_lock");
        set_request(2, 1'b1, rand_addr(2), 8'd1, {$urandom, $urandom}, 8'h0F);
        set_request(0, 1'b0, rand_addr(0), 8'd2, 64'h0, 8'hFF);
        pend = 4'b0001;
        serve_txn(2, 1'b0, 1, 0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            checks++;
            if ({bus.ddr_acquire, bus.ddr_read, bus.ddr_write, bus.w_busy} !== {3'b100, 4'hF}) begin
                errors++;
                $display("[TB] FAIL lock_held: got %b, expected 100_1111",
                         {bus.ddr_acquire, bus.ddr_read, bus.ddr_write, bus.w_busy});
            end
        end
        set_request(2, 1'b0, rand_addr(2), 8'd2, 64'h0, 8'hFF);
        serve_txn(2, 1'b1, 0, 1, 64'h0);
        model_last = 2;
        drain(1, 1);
    endtask

    task automatic test_mid_reset();
        $display("[TB] test_mid_reset");
        set_request(1, 1'b0, rand_addr(1), 8'd3, 64'h0, 8'hFF);
        cyc();
        #1;
        checks++;
        if ({bus.ddr_read, bus.w_busy} !== 5'b1_1101) begin
            errors++;
            $display("[TB] FAIL mr_accept: got %b, expected 1_1101", {bus.ddr_read, bus.w_busy});
        end
        cyc();
        bus.w_read[1]       = 1'b0;
        bus.ddr_rdata       = 64'h5A5A_0001;
        bus.ddr_rdata_ready = 1'b1;
        #1;
        checks++;
        if (bus.w_rdata_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL mr_first_beat: got %b, expected 0010", bus.w_rdata_ready);
        end
        cyc();
        bus.ddr_rdata_ready        = 1'b0;
        bus.w_acquire              = '0;
        reset_dsp_enabled_clk_mpeg = 1'b1;
        cyc();
        reset_dsp_enabled_clk_mpeg = 1'b0;
        #1;
        checks++;
        if ({bus.ddr_acquire, bus.ddr_read, bus.ddr_write, bus.ddr_addr, bus.ddr_burstcnt,
             bus.w_busy, bus.w_rdata_ready} !== {40'h0, 8'hF0}) begin
            errors++;
            $display("[TB] FAIL mr_reset_outputs: got %h, expected %h", {bus.ddr_acquire, bus.ddr_read,
                     bus.ddr_write, bus.ddr_addr, bus.ddr_burstcnt, bus.w_busy, bus.w_rdata_ready},
                     {40'h0, 8'hF0});
        end
        for (int i = 0; i < 2; i++) begin
            bus.ddr_rdata_ready = 1'b1;
            #1;
            checks++;
            if ({bus.ddr_acquire, bus.w_rdata_ready} !== 5'b0_0000) begin
                errors++;
                $display("[TB] FAIL mr_stale_beat %0d: got %b, expected 0_0000", i,
                         {bus.ddr_acquire, bus.w_rdata_ready});
            end
            cyc();
            bus.ddr_rdata_ready = 1'b0;
            cyc();
        end
        model_last = 3;
        set_request(3, 1'b0, rand_addr(3), 8'd2, 64'h0, 8'hFF);
        set_request(1, 1'b1, rand_addr(1), 8'd1, {$urandom, $urandom}, 8'hAA);
        pend = 4'b1010;
        drain(1, 1);
    endtask

    task automatic test_random();
        logic [3:0] mask;
        bit         wr;
        logic [7:0] burst;
        $display("[TB] test_random");
        for (int r = 0; r < 12; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int p = 0; p < 4; p++) begin
                if (mask[p]) begin
                    wr    = 1'($urandom_range(0, 1));
                    burst = wr ? 8'd1 : 8'($urandom_range(0, 4));
                    set_request(p, wr, rand_addr(p), burst, {$urandom, $urandom}, 8'($urandom));
                end
            end
            pend = mask;
            drain(3, 2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_dsp_enabled_clk_mpeg = 1'b1;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_single_read();
        test_write();
        test_hold_lock();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
